// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: receives a big-endian byte stream (word-count header
// followed by instruction words), writes words from address 0 and holds the CPU in reset until done.
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reload,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [31:0]           im_wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    typedef enum logic [2:0] {
        ST_START,
        ST_HDR,
        ST_LOAD,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_WIDTH;

    state_t                state_reg, state_next;
    logic [1:0]            byte_cnt_reg;
    logic [23:0]           shift_reg;
    logic [31:0]           count_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [31:0]           wdata_reg;
    logic [ADDR_WIDTH:0]   loaded_reg;
    logic                  cpu_rst_reg;

    logic        accept;
    logic        word_complete;
    logic [31:0] word_full;
    logic        last_word;

    // reload wins over a coincident byte, so ready is masked combinationally
    assign in_ready      = ((state_reg == ST_HDR) || (state_reg == ST_LOAD)) && !reload;
    assign accept        = in_ready && in_valid;
    assign word_complete = accept && (byte_cnt_reg == 2'd3);
    assign word_full     = {shift_reg, in_data};
    assign last_word     = ({{(32-ADDR_WIDTH){1'b0}}, addr_reg} == (count_reg - 32'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_START;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_START: state_next = ST_HDR;
            ST_HDR: begin
                if (word_complete) begin
                    if (word_full == 32'd0) begin
                        state_next = ST_DONE;
                    end else if ({1'b0, word_full} > CAPACITY) begin
                        state_next = ST_ERR;
                    end else begin
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_LOAD:  if (word_complete) state_next = ST_WRITE;
            ST_WRITE: state_next = last_word ? ST_DONE : ST_LOAD;
            ST_DONE:  state_next = ST_DONE;
            ST_ERR:   state_next = ST_ERR;
            default:  state_next = ST_START;
        endcase
        if (reload) begin
            state_next = ST_HDR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_reg <= 2'd0;
            shift_reg    <= 24'd0;
            count_reg    <= 32'd0;
            addr_reg     <= '0;
            wdata_reg    <= 32'd0;
            loaded_reg   <= '0;
            cpu_rst_reg  <= 1'b1;
        end else begin
            cpu_rst_reg <= (state_next != ST_DONE);
            if (reload) begin
                byte_cnt_reg <= 2'd0;
                addr_reg     <= '0;
                loaded_reg   <= '0;
            end else begin
                if (accept) begin
                    byte_cnt_reg <= byte_cnt_reg + 2'd1;
                    shift_reg    <= {shift_reg[15:0], in_data};
                end
                if (word_complete && (state_reg == ST_HDR)) begin
                    count_reg  <= word_full;
                    addr_reg   <= '0;
                    loaded_reg <= '0;
                end
                if (word_complete && (state_reg == ST_LOAD)) begin
                    wdata_reg <= word_full;
                end
                // the final address is left in place so a full-capacity load never wraps
                if (state_reg == ST_WRITE) begin
                    loaded_reg <= loaded_reg + {{ADDR_WIDTH{1'b0}}, 1'b1};
                    if (!last_word) begin
                        addr_reg <= addr_reg + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
            end
        end
    end

    assign im_we        = (state_reg == ST_WRITE);
    assign im_addr      = addr_reg;
    assign im_wdata     = wdata_reg;
    assign cpu_rst      = cpu_rst_reg;
    assign busy         = (state_reg == ST_HDR) || (state_reg == ST_LOAD) || (state_reg == ST_WRITE);
    assign done         = (state_reg == ST_DONE);
    assign error        = (state_reg == ST_ERR);
    assign words_loaded = loaded_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: byte streams are built from programs and the
// expected memory writes are derived from the header/word layout of the stream.
module tb_imem_loader;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst, reload, in_valid, in_ready, im_we, cpu_rst, busy, done, error;
    logic [7:0]    in_data;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic [AW:0]   words_loaded;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .reload(reload), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    wr_t         wr_q[$];
    wr_t         exp_q[$];
    logic [7:0]  stim_q[$];
    logic [31:0] words_q[$];
    int          acc_q[$];
    logic        exp_err;
    int          exp_wl;

    localparam logic [45:0] RESET_VEC = {1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};

    always @(posedge clk) cyc <= cyc + 1;

    // write monitor plus the cpu_rst/done relationship on every cycle
    always @(negedge clk) begin
        if (im_we) wr_q.push_back('{cyc, im_addr, im_wdata});
        checks++;
        if (cpu_rst !== ~done)
            $display("FAIL cpu_rst_vs_done cyc=%0d got cpu_rst=%b done=%b expected cpu_rst=~done", cyc, cpu_rst, done);
        else passes++;
    end

    task automatic make_prog(input logic [31:0] hdr);
        stim_q.delete();
        for (int i = 3; i >= 0; i--) stim_q.push_back(hdr[8*i +: 8]);
        foreach (words_q[j])
            for (int i = 3; i >= 0; i--) stim_q.push_back(words_q[j][8*i +: 8]);
    endtask

    task automatic random_words(input int n);
        words_q.delete();
        for (int j = 0; j < n; j++) words_q.push_back($urandom);
    endtask

    task automatic fixed_words();
        words_q.delete();
        words_q.push_back(32'h3C010000);
        words_q.push_back(32'h34210007);
        words_q.push_back(32'h8C240000);
    endtask

    // reference: header = first 4 bytes big-endian; each later group of 4 bytes is one word at
    // the next address, written one cycle after its last byte is taken
    task automatic model();
        logic [31:0] hdr;
        int n;
        exp_q.delete();
        hdr = {stim_q[0], stim_q[1], stim_q[2], stim_q[3]};
        exp_err = (hdr > 32'd16);
        n = exp_err ? 0 : int'(hdr);
        for (int j = 0; j < n; j++) begin
            wr_t w;
            w.addr = AW'(j);
            w.data = {stim_q[4+4*j], stim_q[5+4*j], stim_q[6+4*j], stim_q[7+4*j]};
            w.cyc  = (acc_q.size() > 4*j+7) ? acc_q[4*j+7] + 1 : -1;
            exp_q.push_back(w);
        end
        exp_wl = n;
    endtask

    task automatic run_stream(input int gap_pct);
        int idx = 0;
        int budget = 0;
        acc_q.delete();
        while (idx < stim_q.size() && budget < 3000) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = in_valid ? stim_q[idx] : 8'($urandom_range(255));
            @(negedge clk);
            if (in_valid && in_ready) begin
                acc_q.push_back(cyc);
                idx++;
            end
            budget++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (idx != stim_q.size())
            $display("FAIL stream_accept got=%0d bytes expected=%0d", idx, stim_q.size());
        else passes++;
    endtask

    task automatic do_reload();
        @(posedge clk); #1;
        reload = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        reload = 1'b0;
    endtask

    task automatic wait_settle();
        int n = 0;
        @(negedge clk);
        while (!done && !error && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; reload = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        @(negedge clk);
        checks++;
        if ({in_ready, im_we, im_addr, im_wdata, cpu_rst, busy, done, error, words_loaded} !== RESET_VEC)
            $display("FAIL reset_outputs got=%h expected=%h",
                     {in_ready, im_we, im_addr, im_wdata, cpu_rst, busy, done, error, words_loaded}, RESET_VEC);
        else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL start_state got busy=%b in_ready=%b expected 0 0", busy, in_ready);
        else passes++;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1)
            $display("FAIL hdr_state got busy=%b in_ready=%b expected 1 1", busy, in_ready);
        else passes++;
    endtask

    task automatic test_program(input string name, input logic [31:0] hdr, input int gap_pct);
        do_reload();
        wr_q.delete();
        make_prog(hdr);
        run_stream(gap_pct);
        model();
        wait_settle();
        checks++;
        if (wr_q.size() != exp_q.size())
            $display("FAIL %s_write_count got=%0d expected=%0d", name, wr_q.size(), exp_q.size());
        else passes++;
        foreach (exp_q[j]) if (j < wr_q.size()) begin
            checks++;
            if (wr_q[j].addr !== exp_q[j].addr || wr_q[j].data !== exp_q[j].data || wr_q[j].cyc != exp_q[j].cyc)
                $display("FAIL %s_write%0d got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d", name, j,
                         wr_q[j].addr, wr_q[j].data, wr_q[j].cyc, exp_q[j].addr, exp_q[j].data, exp_q[j].cyc);
            else passes++;
        end
        checks++;
        if (words_loaded !== (AW+1)'(exp_wl) || done !== !exp_err || error !== exp_err || cpu_rst !== exp_err)
            $display("FAIL %s_final got wl=%0d done=%b error=%b cpu_rst=%b expected wl=%0d done=%b error=%b cpu_rst=%b",
                     name, words_loaded, done, error, cpu_rst, exp_wl, !exp_err, exp_err, exp_err);
        else passes++;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s_idle got in_ready=%b busy=%b expected 0 0", name, in_ready, busy);
        else passes++;
    endtask

    task automatic test_basic();
        fixed_words();
        test_program("basic", 32'd3, 0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'h55;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) $display("FAIL done_refuses got in_ready=%b expected 0", in_ready);
            else passes++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_q.size() != 3 || words_loaded !== 5'd3 || im_addr !== 4'd2)
            $display("FAIL done_hold got writes=%0d wl=%0d addr=%0d expected 3 3 2", wr_q.size(), words_loaded, im_addr);
        else passes++;
    endtask

    task automatic test_boundaries();
        words_q.delete();
        test_program("zero_hdr", 32'd0, 0);
        test_program("overflow", 32'h11, 0);
        repeat (5) @(negedge clk);
        checks++;
        if (error !== 1'b1 || cpu_rst !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL err_sticky got error=%b cpu_rst=%b in_ready=%b expected 1 1 0", error, cpu_rst, in_ready);
        else passes++;
        random_words(16);
        test_program("full", 32'h10, 0);
        checks++;
        if (im_addr !== 4'd15) $display("FAIL full_last_addr got=%0d expected=15", im_addr);
        else passes++;
    endtask

    task automatic test_gaps();
        for (int r = 0; r < 3; r++) begin
            fixed_words();
            test_program("gaps", 32'd3, 50);
        end
        random_words(5);
        test_program("gaps_rand", 32'd5, 50);
    endtask

    task automatic test_reload_mid();
        do_reload();
        wr_q.delete();
        random_words(3);
        make_prog(32'd3);
        while (stim_q.size() > 10) void'(stim_q.pop_back());
        run_stream(0);
        @(negedge clk);
        checks++;
        if (words_loaded !== 5'd1 || wr_q.size() != 1)
            $display("FAIL pre_reload got wl=%0d writes=%0d expected 1 1", words_loaded, wr_q.size());
        else passes++;
        @(posedge clk); #1;
        reload = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) $display("FAIL reload_masks_ready got=%b expected 0", in_ready);
        else passes++;
        @(posedge clk); #1;
        reload = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || words_loaded !== 5'd0 || cpu_rst !== 1'b1 || im_addr !== 4'd0)
            $display("FAIL after_reload got busy=%b rdy=%b wl=%0d cpu_rst=%b addr=%0d expected 1 1 0 1 0",
                     busy, in_ready, words_loaded, cpu_rst, im_addr);
        else passes++;
        random_words(2);
        test_program("post_reload", 32'd2, 20);
    endtask

    task automatic test_async_rst();
        do_reload();
        random_words(3);
        make_prog(32'd3);
        while (stim_q.size() > 9) void'(stim_q.pop_back());
        run_stream(0);
        @(negedge clk);
        checks++;
        if (words_loaded !== 5'd1 || im_addr !== 4'd1)
            $display("FAIL pre_rst got wl=%0d addr=%0d expected 1 1", words_loaded, im_addr);
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, im_we, im_addr, im_wdata, cpu_rst, busy, done, error, words_loaded} !== RESET_VEC)
            $display("FAIL async_rst got=%h expected=%h",
                     {in_ready, im_we, im_addr, im_wdata, cpu_rst, busy, done, error, words_loaded}, RESET_VEC);
        else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
        wr_q.delete();
        random_words(4);
        make_prog(32'd4);
        run_stream(30);
        model();
        wait_settle();
        checks++;
        if (wr_q.size() != 4 || words_loaded !== 5'd4 || done !== 1'b1)
            $display("FAIL after_rst_load got writes=%0d wl=%0d done=%b expected 4 4 1", wr_q.size(), words_loaded, done);
        else passes++;
        foreach (exp_q[j]) if (j < wr_q.size()) begin
            checks++;
            if (wr_q[j].addr !== exp_q[j].addr || wr_q[j].data !== exp_q[j].data)
                $display("FAIL after_rst_write%0d got addr=%0d data=%h expected addr=%0d data=%h", j,
                         wr_q[j].addr, wr_q[j].data, exp_q[j].addr, exp_q[j].data);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_gaps();
        test_reload_mid();
        test_async_rst();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the processor top (`main`) and its instruction memory.
- Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them sequentially into instruction memory from address 0.
- Holds the processor in reset until the whole program is loaded.
- Replaces hierarchical preloading of `im.memory` from benches and enables loading from a UART/host link.

Parameters:
- ADDR_WIDTH, 10, instruction-memory word-address width; capacity = 2**ADDR_WIDTH words.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high; one clock only
- reload  input  1  synchronous pulse: restart loading from scratch
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader can accept a byte; byte accepted when in_valid && in_ready
- im_we  output  1  instruction-memory write strobe, one cycle per word
- im_addr  output  ADDR_WIDTH  instruction-memory word address
- im_wdata  output  32  instruction word to write
- cpu_rst  output  1  reset to processor, high except in DONE
- busy  output  1  loading in progress (HDR, LOAD or WRITE)
- done  output  1  program fully loaded
- error  output  1  header word count exceeded capacity
- words_loaded  output  ADDR_WIDTH+1  count of words written since last header

Behaviour:
- States: START, HDR, LOAD, WRITE, DONE, ERR. Reset state START.
- Reset values: in_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_rst=1, busy=0, done=0, error=0, words_loaded=0. Internal byte counter=0, count=0.
- START: one cycle after reset deassertion, then HDR.
- Byte assembly: a 2-bit byte counter and shift register. The first accepted byte goes to bits 31:24 and the fourth to bits 7:0. Identical rules apply in HDR and LOAD.
- HDR: in_ready=1, busy=1. On the 4th accepted byte the assembled value becomes count, a 32-bit unsigned value.
  - count==0 -> DONE.
  - count > 2**ADDR_WIDTH -> ERR.
  - Otherwise -> LOAD with im_addr=0.
- LOAD: in_ready=1, busy=1. On the 4th accepted byte, register im_wdata and go to WRITE.
- WRITE: exactly one cycle. im_we=1, in_ready=0, busy=1; im_addr and im_wdata are stable. words_loaded increments at the end of the cycle.
  - If im_addr == count-1 -> DONE. im_addr is not incremented, so there is no wrap at full capacity.
  - Otherwise im_addr increments and the FSM returns to LOAD.
- Latency: im_we asserts the cycle after the 4th byte of a word is accepted.
- DONE: cpu_rst=0, done=1, in_ready=0. Extra bytes are not accepted. im_addr and words_loaded hold.
- ERR: error=1, cpu_rst=1, in_ready=0. Sticky until rst or reload.
- cpu_rst is registered and deasserts on the same edge that enters DONE.
- reload (any state, including mid-word): next state HDR. The byte counter clears, any partial word is discarded, and words_loaded, im_addr, done and error are all cleared. cpu_rst=1.
  - in_ready is forced 0 combinationally while reload=1, so a simultaneous in_valid byte is dropped.
  - Memory contents already written are left as-is.
- Stalls: in_valid low for any number of cycles leaves all state unchanged. There is no timeout.
- Async rst mid-load returns to START immediately. The next load must start with a fresh header.
- Exactly 2**ADDR_WIDTH words fills the memory and enters DONE without error.

Test Plan:
- Header 0x00000003, words 0x3C010000, 0x34210007, 0x8C240000, in_valid always high:
  - Three im_we pulses at addresses 0,1,2 with those data values.
  - im_we rises 1 cycle after each 4th byte.
  - words_loaded=3, done=1, cpu_rst falls on entry to DONE.
- Header 0x00000000 -> DONE directly, no im_we, words_loaded=0, cpu_rst=0.
- ADDR_WIDTH=4:
  - Header 0x00000011 -> ERR, error=1, cpu_rst=1, in_ready=0.
  - Header 0x00000010 with 16 words -> last write at addr 15, done=1, error=0.
- Random in_valid gaps (~50%) on the 3-word program -> identical writes and data to the first test; no byte lost or duplicated.
- reload asserted after 2 bytes of word 1, together with in_valid:
  - That byte is dropped, FSM goes to HDR, words_loaded=0, cpu_rst=1.
  - A new 2-word program is then written at addresses 0 and 1.
- Async rst mid-LOAD -> all outputs return to reset values immediately; a full reload afterwards succeeds.
